// File: rtl/image_stream_out.sv
// image_stream_out
//   Output stage behind the image processor. Processed RGB pixels arrive as
//   single-cycle strobes. They are buffered in a first-word-fall-through FIFO.
//   The FIFO is drained on a ready/valid stream that carries frame position
//   markers.
//
// Optional feature macro: FRAME_CHECKSUM_EN
//   When defined, a 16-bit wrapping sum of R+G+B over every transferred pixel
//   is reported once per frame on frame_checksum / checksum_valid.
//   When undefined, both of those outputs are tied to zero.
//
// Parameters
//   IMAGE_WIDTH   pixels per line
//   IMAGE_HEIGHT  lines per frame
//   FIFO_DEPTH    FIFO entries (power of two, >= 4)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pixel_in          24-bit {R,G,B} pixel, qualified by pixel_strobe_in
//   pixel_strobe_in   one-cycle pulse per new pixel
//   frame_done_in     one-cycle pulse after upstream's last pixel of a frame
//   m_data/m_valid/m_ready   output stream handshake
//   m_sof/m_eol/m_eof        start-of-frame / end-of-line / end-of-frame markers
//   fifo_level        current FIFO occupancy
//   overflow          sticky: a strobe arrived while the FIFO was full
//   frame_err         one-cycle pulse: wrong pixel count at frame_done_in
//   frame_checksum    per-frame checksum
//   checksum_valid    one-cycle pulse when frame_checksum updates
module image_stream_out #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [23:0]                   pixel_in,
    input  logic                          pixel_strobe_in,
    input  logic                          frame_done_in,
    output logic [23:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          m_eof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [15:0]                   frame_checksum,
    output logic                          checksum_valid
);

    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW           = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    // One spare bit so that a long frame can be told apart from a full one
    // before the counter saturates.
    localparam int ICW          = $clog2(FRAME_PIXELS + 1) + 1;

    localparam logic [CW-1:0]  COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [AW:0]    LEVEL_MAX = (AW + 1)'(FIFO_DEPTH);
    localparam logic [ICW-1:0] CNT_FRAME = ICW'(FRAME_PIXELS);
    localparam logic [ICW-1:0] CNT_MAX   = '1;

    logic [23:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    level_reg;
    logic [CW-1:0]  col_reg;
    logic [RW-1:0]  row_reg;
    logic [ICW-1:0] in_cnt_reg;
    logic           overflow_reg;
    logic           frame_err_reg;

    logic full;
    logic wr_en;
    logic xfer;

    // Full is taken from the registered level only. A strobe that arrives
    // while the FIFO is full is therefore dropped, even if a read frees an
    // entry in the same cycle.
    assign full    = (level_reg == LEVEL_MAX);
    assign wr_en   = pixel_strobe_in && !full;
    assign m_valid = (level_reg != '0);
    assign xfer    = m_valid && m_ready;

    // Asynchronous read gives first-word-fall-through. Data is forced to
    // zero while empty, so that stale entries are never presented.
    assign m_data  = m_valid ? mem[rd_ptr_reg] : 24'd0;

    assign m_sof   = m_valid && (col_reg == '0) && (row_reg == '0);
    assign m_eol   = m_valid && (col_reg == COL_LAST);
    assign m_eof   = m_eol && (row_reg == ROW_LAST);

    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;
    assign frame_err  = frame_err_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            in_cnt_reg    <= '0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pixel_strobe_in && full) begin
                overflow_reg <= 1'b1;
            end
            if (xfer) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_en && !xfer) begin
                level_reg <= level_reg + 1'b1;
            end else if (xfer && !wr_en) begin
                level_reg <= level_reg - 1'b1;
            end

            // Position of the head pixel moves only when it is handed off.
            // No resynchronisation is done against frame_done_in.
            if (xfer) begin
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end

            // A strobe in the same cycle as frame_done_in belongs to the next
            // frame. The counter saturates, so very long frames cannot alias
            // back to a correct count.
            frame_err_reg <= frame_done_in && (in_cnt_reg != CNT_FRAME);
            if (frame_done_in) begin
                in_cnt_reg <= pixel_strobe_in ? ICW'(1) : '0;
            end else if (pixel_strobe_in && (in_cnt_reg != CNT_MAX)) begin
                in_cnt_reg <= in_cnt_reg + 1'b1;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] acc_reg;
    logic [15:0] checksum_reg;
    logic        checksum_valid_reg;
    logic [15:0] pix_sum;

    assign pix_sum = 16'(m_data[23:16]) + 16'(m_data[15:8]) + 16'(m_data[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg            <= '0;
            checksum_reg       <= '0;
            checksum_valid_reg <= 1'b0;
        end else begin
            checksum_valid_reg <= 1'b0;
            if (xfer) begin
                if (m_eof) begin
                    checksum_reg       <= acc_reg + pix_sum;
                    checksum_valid_reg <= 1'b1;
                    acc_reg            <= '0;
                end else begin
                    acc_reg <= acc_reg + pix_sum;
                end
            end
        end
    end

    assign frame_checksum = checksum_reg;
    assign checksum_valid = checksum_valid_reg;
`else
    assign frame_checksum = 16'd0;
    assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_image_stream_out.sv
// Bench for image_stream_out on a 4x2 frame with a 4-entry FIFO.
// A queue-based model predicts every output on every cycle. Directed steps
// also carry hand-computed literal expectations.
module tb_image_stream_out;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pixel_in;
    logic        pixel_strobe_in;
    logic        frame_done_in;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_checksum;
    logic        checksum_valid;

    int checks = 0;
    int errors = 0;

    image_stream_out #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_strobe_in(pixel_strobe_in),
        .frame_done_in  (frame_done_in),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_sof          (m_sof),
        .m_eol          (m_eol),
        .m_eof          (m_eof),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .frame_err      (frame_err),
        .frame_checksum (frame_checksum),
        .checksum_valid (checksum_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] q[$];
    int          out_idx;     // index of the head pixel within the frame
    int          in_cnt_m;
    bit          ovf_m;
    bit          ferr_m;
    int          acc_m;
    int          cks_m;
    bit          csv_m;
    bit          live = 0;
    bit          xfer_m;
    bit          full_m;
    logic [23:0] head_m;
    int          sum_m;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            out_idx  = 0;
            in_cnt_m = 0;
            ovf_m    = 0;
            ferr_m   = 0;
            acc_m    = 0;
            cks_m    = 0;
            csv_m    = 0;
            live     = 1;
        end else begin
            xfer_m = (q.size() != 0) && m_ready;
            full_m = (q.size() >= D);
            ferr_m = 0;
            csv_m  = 0;
            if (xfer_m) begin
                head_m = q.pop_front();
                sum_m  = int'(head_m[23:16]) + int'(head_m[15:8]) + int'(head_m[7:0]);
                if (out_idx == W*H-1) begin
                    cks_m = (acc_m + sum_m) % 65536;
                    csv_m = 1;
                    acc_m = 0;
                end else begin
                    acc_m = (acc_m + sum_m) % 65536;
                end
                out_idx = (out_idx + 1) % (W*H);
            end
            if (pixel_strobe_in) begin
                if (full_m) ovf_m = 1;
                else        q.push_back(pixel_in);
            end
            if (frame_done_in) begin
                ferr_m   = (in_cnt_m != W*H);
                in_cnt_m = pixel_strobe_in ? 1 : 0;
            end else if (pixel_strobe_in) begin
                in_cnt_m++;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (live) begin
            chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("overflow", 32'(overflow), 32'(ovf_m));
            chk("frame_err", 32'(frame_err), 32'(ferr_m));
            if (q.size() != 0) begin
                chk("m_data", 32'(m_data), 32'(q[0]));
                chk("m_sof", 32'(m_sof), 32'(out_idx == 0));
                chk("m_eol", 32'(m_eol), 32'((out_idx % W) == W-1));
                chk("m_eof", 32'(m_eof), 32'(out_idx == W*H-1));
            end else begin
                chk("markers_idle", {29'd0, m_sof, m_eol, m_eof}, 32'd0);
            end
`ifdef FRAME_CHECKSUM_EN
            chk("checksum_valid", 32'(checksum_valid), 32'(csv_m));
            chk("frame_checksum", 32'(frame_checksum), 32'(cks_m));
`else
            chk("checksum_valid", 32'(checksum_valid), 32'd0);
            chk("frame_checksum", 32'(frame_checksum), 32'd0);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] v);
        pixel_in        = v;
        pixel_strobe_in = 1'b1;
        tick();
        pixel_strobe_in = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        pixel_in        = '0;
        pixel_strobe_in = 1'b0;
        frame_done_in   = 1'b0;
        m_ready         = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset, then idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(m_valid), 32'd0);
            chk("idle_level", 32'(fifo_level), 32'd0);
            chk("idle_data", 32'(m_data), 32'd0);
            chk("idle_flags", {27'd0, overflow, frame_err, m_sof, m_eol, m_eof}, 32'd0);
            chk("idle_cks", {15'd0, checksum_valid, frame_checksum}, 32'd0);
        end
        $display("idle: 10 cycles checked");

        // Streaming frame 1..8, each pixel at the head one cycle after its strobe
        m_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            strobe(24'(v));
            chk("fr_data", 32'(m_data), 32'(v));
            chk("fr_sof", 32'(m_sof), 32'(v == 1));
            chk("fr_eol", 32'(m_eol), 32'(v == 4 || v == 8));
            chk("fr_eof", 32'(m_eof), 32'(v == 8));
            $display("frame pixel %0d: data=%h sof=%b eol=%b eof=%b", v, m_data, m_sof, m_eol, m_eof);
        end
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        chk("fr_done_ok", 32'(frame_err), 32'd0);
        $display("frame_done after 8 strobes: frame_err=%b", frame_err);

        // Overflow: 6 strobes into a stalled 4-deep FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) strobe(24'h10 + 24'(i));
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_valid", 32'(m_valid), 32'd1);
            chk("ovf_drain_data", 32'(m_data), 32'h10 + 32'(i));
            tick();
        end
        chk("ovf_empty", 32'(m_valid), 32'd0);
        $display("overflow: level=4 overflow=%b drained 10..13", overflow);

        // Full FIFO, strobe and transfer in the same cycle
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(24'h20 + 24'(i));
        m_ready = 1'b1;
        strobe(24'h24);
        chk("fullrw_level", 32'(fifo_level), 32'd3);
        chk("fullrw_head", 32'(m_data), 32'h21);
        chk("fullrw_ovf", 32'(overflow), 32'd1);
        repeat (3) tick();
        chk("fullrw_empty", 32'(m_valid), 32'd0);
        $display("full+read same cycle: level=3, strobe 24 dropped");

        // Reset mid-stream discards FIFO contents
        m_ready = 1'b0;
        strobe(24'h31);
        strobe(24'h32);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        $display("mid-stream reset: level=%0d", fifo_level);

        // Short frame (7 strobes), then a correct frame (8 strobes)
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) strobe(24'h40 + 24'(i));
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        chk("short_err", 32'(frame_err), 32'd1);
        tick();
        chk("short_err_pulse", 32'(frame_err), 32'd0);
        $display("short frame: frame_err pulsed");
        for (int i = 0; i < 8; i++) strobe(24'h50 + 24'(i));
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        chk("good_err", 32'(frame_err), 32'd0);
        $display("full frame: frame_err=%b", frame_err);
        tick();

        // Checksum: 8 pixels of 0x010203, each summing to 6
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) strobe(24'h010203);
        tick();
`ifdef FRAME_CHECKSUM_EN
        chk("cks_valid", 32'(checksum_valid), 32'd1);
        chk("cks_value", 32'(frame_checksum), 32'h0030);
`else
        chk("cks_valid", 32'(checksum_valid), 32'd0);
        chk("cks_value", 32'(frame_checksum), 32'h0000);
`endif
        $display("checksum: valid=%b value=%h", checksum_valid, frame_checksum);
        tick();
        chk("cks_pulse", 32'(checksum_valid), 32'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_stream_out.md
# image_stream_out

Output-side stage that sits directly downstream of the image processor. It accepts processed 24-bit RGB pixels as single-cycle strobes and buffers them in a small first-word-fall-through FIFO. It presents them on a ready/valid stream with start-of-frame, end-of-line and end-of-frame markers, and flags dropped pixels and short or long frames.

## Interface
- IMAGE_WIDTH, 512, pixels per line
- IMAGE_HEIGHT, 512, lines per frame
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 4
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pixel_in  input  24  processed pixel {R,G,B}
- pixel_strobe_in  input  1  one-cycle pulse per new pixel_in
- frame_done_in  input  1  one-cycle pulse from upstream after its last pixel
- m_data  output  24  stream pixel
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts when high with m_valid
- m_sof  output  1  first pixel of frame (row 0, col 0)
- m_eol  output  1  last pixel of a line (col == IMAGE_WIDTH-1)
- m_eof  output  1  last pixel of frame
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  output  1  sticky: a strobe arrived while FIFO full
- frame_err  output  1  one-cycle pulse: strobe count at frame_done_in ≠ IMAGE_WIDTH*IMAGE_HEIGHT
- frame_checksum  output  16  per-frame checksum (see Configuration)
- checksum_valid  output  1  one-cycle pulse when frame_checksum updates

## Operation
- Write: pixel_strobe_in && !full → pixel_in written at wr_ptr, wr_ptr+1 (wraps mod FIFO_DEPTH). pixel_strobe_in && full → pixel dropped, overflow ← 1 until rst.
- full/empty from registered fifo_level only; a strobe while full is dropped even if a read happens the same cycle.
- Read: m_valid = (fifo_level ≠ 0); m_data = entry at rd_ptr. Transfer = m_valid && m_ready → rd_ptr+1, fifo_level−1.
- Simultaneous accepted write and transfer: fifo_level unchanged.
- m_data/m_valid stable while m_valid && !m_ready.
- Output position counters col (0..IMAGE_WIDTH-1), row (0..IMAGE_HEIGHT-1) advance only on transfer; col wraps to 0 and row+1 at line end; both wrap to 0 after the eof pixel.
- m_sof = m_valid && col==0 && row==0; m_eol = m_valid && col==IMAGE_WIDTH-1; m_eof = m_eol && row==IMAGE_HEIGHT-1. All combinational from the head pixel's position.
- Input counter in_cnt counts every pixel_strobe_in (accepted or dropped). On frame_done_in: frame_err pulses next cycle if in_cnt ≠ IMAGE_WIDTH*IMAGE_HEIGHT; in_cnt ← 0 (a strobe in the same cycle counts toward the new frame, in_cnt ← 1).
- Position counters are not resynchronised by frame_done_in; a dropped pixel shifts markers until rst.

## Timing
- Reset: fifo_level, pointers, col, row, in_cnt = 0; m_valid, m_sof, m_eol, m_eof, overflow, frame_err, checksum_valid = 0; m_data = 0; frame_checksum = 0.
- Latency: strobe at cycle N into empty FIFO → m_valid = 1 in cycle N+1.
- Throughput: one write and one transfer per cycle.
- rst mid-frame: FIFO contents discarded, pending markers cleared, next strobe is treated as frame pixel 0.

## Configuration
- FRAME_CHECKSUM_EN defined: accumulator acc (16-bit, wrapping) adds R+G+B of each transferred pixel. On the eof transfer, frame_checksum ← acc + that pixel's sum, checksum_valid pulses the next cycle, acc ← 0. rst clears acc.
- Undefined: no accumulator; frame_checksum = 0, checksum_valid = 0 permanently.

## Test plan
- Reset then idle: all outputs 0, fifo_level 0, m_valid 0 for 10 cycles.
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, 8 strobes of 0x000001..0x000008, m_ready=1 → m_data 1..8 each one cycle after its strobe. m_sof on 1, m_eol on 4 and 8, m_eof on 8. frame_done_in after → no frame_err.
- FIFO_DEPTH=4, m_ready=0, 6 back-to-back strobes → fifo_level 4, overflow=1. Then m_ready=1 → first 4 pixels out in order, then m_valid 0.
- Full FIFO, strobe and transfer in the same cycle → strobe dropped, overflow=1, fifo_level 3 next cycle.
- 7 strobes then frame_done_in (4×2 frame) → frame_err pulse one cycle later. Next frame of 8 strobes + frame_done_in → no pulse.
- FRAME_CHECKSUM_EN, 4×2 frame of 0x010203 each → checksum_valid pulse after eof transfer, frame_checksum = 0x0030. Without the macro → stays 0.
